reg_arbiter2: RTL and testbench

REG_ARBITER2 -- requirements
Module: reg_arbiter2

---
 rtl/reg_arb_pkg.sv | 19 +
 rtl/reg32_en.sv | 22 ++
 rtl/reg_arbiter2.sv | 125 ++++++++++++
 tb/tb_reg_arbiter2.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the two-requester register arbiter.
// State encoding, default widths and the arbitration pick helper live here.
package reg_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Returns the winning requester index; prefer1 breaks ties toward requester 1.
    function automatic logic arb_pick(input logic r0, input logic r1, input logic prefer1);
        return r1 & (~r0 | prefer1);
    endfunction

endpackage

// File: rtl/reg32_en.sv
// Single storage register with synchronous active-low reset and load enable.
module reg32_en
    import reg_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_arbiter2.sv
// Two-requester register file arbiter: IDLE -> BUSY -> ACK per transaction.
// Define REG_ARB_RR_EN for round-robin contention; otherwise req0 has fixed priority.
module reg_arbiter2
    import reg_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              grant_id
);

    localparam int NREG = 2 ** ADDR_W;

    state_t            state;
    logic              lat_id;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              winner;
    logic              prefer1;
    logic [NREG-1:0]   reg_en;
    logic [DATA_W-1:0] reg_q [NREG];
    logic [DATA_W-1:0] rd_next;

`ifdef REG_ARB_RR_EN
    // Resets to 1 so requester 0 wins the first contested arbitration.
    logic last_id;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_id <= 1'b1;
        end else if (state == ST_IDLE && (req0 || req1)) begin
            last_id <= winner;
        end
    end

    assign prefer1 = ~last_id;
`else
    assign prefer1 = 1'b0;
`endif

    assign winner = arb_pick(req0, req1, prefer1);

    always_comb begin
        reg_en = '0;
        if (state == ST_BUSY && lat_we) begin
            reg_en[lat_addr] = 1'b1;
        end
    end

    // A write returns the value being stored, which is the post-write content.
    assign rd_next = lat_we ? lat_wdata : reg_q[lat_addr];

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        reg32_en #(.DATA_W(DATA_W)) u_reg (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (reg_en[i]),
            .d       (lat_wdata),
            .q       (reg_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            busy      <= 1'b0;
            rdata     <= '0;
            grant_id  <= 1'b0;
            lat_id    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        lat_id    <= winner;
                        lat_we    <= winner ? we1    : we0;
                        lat_addr  <= winner ? addr1  : addr0;
                        lat_wdata <= winner ? wdata1 : wdata0;
                        state     <= ST_BUSY;
                        busy      <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    rdata    <= rd_next;
                    grant_id <= lat_id;
                    ack0     <= ~lat_id;
                    ack1     <= lat_id;
                    state    <= ST_ACK;
                    busy     <= 1'b1;
                end
                ST_ACK: begin
                    // Requests are not sampled here; the served requester drops req on this edge.
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_arbiter2.sv
// Randomized scoreboard bench for reg_arbiter2 against a transaction-level register model.
module tb_reg_arbiter2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [1:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, busy, grant_id;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    // Expected transactions per requester: {we, addr, wdata}.
    logic [34:0] exp_q0[$];
    logic [34:0] exp_q1[$];
    logic [31:0] model_mem [4];
    int          served[$];
    logic        prev_ack0 = 1'b0, prev_ack1 = 1'b0;

    reg_arbiter2 #(.DATA_W(32), .ADDR_W(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .ack0     (ack0),
        .ack1     (ack1),
        .rdata    (rdata),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int id, input logic r, input logic w, input logic [1:0] a,
                         input logic [31:0] d);
        if (id == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // Caller aligns to #1 after a rising edge. exp_lat 0 skips the latency check.
    task automatic do_req(input int id, input logic w, input logic [1:0] a, input logic [31:0] d,
                          input int exp_lat, input bit corrupt);
        int lat;
        bit seen;
        if (id == 0) exp_q0.push_back({w, a, d});
        else         exp_q1.push_back({w, a, d});
        drive(id, 1'b1, w, a, d);
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            lat++;
            if (corrupt && k == 1) begin
                if (id == 0) wdata0 = 32'h33221100;
                else         wdata1 = 32'h33221100;
            end
            if ((id == 0) ? ack0 : ack1) seen = 1'b1;
        end
        if (!seen) begin
            chk($sformatf("ack_timeout_req%0d", id), 32'd0, 32'd1);
        end else if (exp_lat > 0) begin
            chk($sformatf("latency_req%0d", id), lat, exp_lat);
        end
        @(posedge clk);
        #1;
        drive(id, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic handle_ack(input int id);
        logic [34:0] t;
        logic [31:0] exp_rd;
        checks++;
        if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_ack%0d: got ack with no pending request", id);
            return;
        end
        t = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        if (t[34]) model_mem[t[33:32]] = t[31:0];
        exp_rd = model_mem[t[33:32]];
        served.push_back(id);
        chk($sformatf("rdata_req%0d", id), rdata, exp_rd);
        chk($sformatf("grant_id_req%0d", id), {31'd0, grant_id}, id);
        chk("busy_in_ack", {31'd0, busy}, 32'd1);
    endtask

    // Monitor: pops and compares whenever an ack is presented.
    always @(negedge clk) begin
        if (reset_n) begin
            if (ack0 || ack1) chk("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
            if (ack0 && prev_ack0) chk("ack0_width", 32'd2, 32'd1);
            if (ack1 && prev_ack1) chk("ack1_width", 32'd2, 32'd1);
            if (ack0) handle_ack(0);
            if (ack1) handle_ack(1);
        end
        prev_ack0 = ack0;
        prev_ack1 = ack1;
    end

    task automatic check_idle_reset(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_ack0"}, {31'd0, ack0}, 32'd0);
        chk({tag, "_ack1"}, {31'd0, ack1}, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_grant_id"}, {31'd0, grant_id}, 32'd0);
    endtask

    task automatic check_served(input int exp_ids[$]);
        chk("served_count", served.size(), exp_ids.size());
        for (int i = 0; i < exp_ids.size() && i < served.size(); i++) begin
            chk($sformatf("served_order_%0d", i), served[i], exp_ids[i]);
        end
    endtask

    initial begin
        int exp_ids[$];
        for (int i = 0; i < 4; i++) model_mem[i] = 32'd0;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_reset("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Never-written address reads zero; single-cycle ack checked by the monitor.
        do_req(0, 1'b0, 2'd2, 32'd0, 3, 1'b0);
        @(negedge clk);
        chk("ack0_after_pulse", {31'd0, ack0}, 32'd0);
        @(posedge clk); #1;

        do_req(0, 1'b1, 2'd1, 32'h12345678, 3, 1'b0);
        do_req(1, 1'b0, 2'd1, 32'd0, 3, 1'b0);

        // Simultaneous requests: requester 0 first, requester 1 three cycles later.
        served.delete();
        fork
            do_req(0, 1'b1, 2'd2, 32'h98765432, 3, 1'b0);
            do_req(1, 1'b1, 2'd3, 32'hffeeddcc, 6, 1'b0);
        join
        exp_ids = '{0, 1};
        check_served(exp_ids);
        do_req(0, 1'b0, 2'd2, 32'd0, 3, 1'b0);
        do_req(1, 1'b0, 2'd3, 32'd0, 3, 1'b0);

        // Operand change during BUSY must not affect the latched write.
        do_req(1, 1'b1, 2'd3, 32'h5a5a0ff0, 3, 1'b1);
        do_req(1, 1'b0, 2'd3, 32'd0, 3, 1'b0);

        // Reset during BUSY of a write to register 0.
        do_req(0, 1'b1, 2'd0, 32'h0a0a0a0a, 3, 1'b0);
        drive(0, 1'b1, 1'b1, 2'd0, 32'hbbaaccdd);
        @(posedge clk); #1;
        reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, 2'd0, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) model_mem[i] = 32'd0;
        @(negedge clk);
        check_idle_reset("busy_reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Pointer restarts so requester 0 wins the first contest.
        served.delete();
        fork
            do_req(0, 1'b1, 2'd1, 32'h11112222, 3, 1'b0);
            do_req(1, 1'b1, 2'd2, 32'h33334444, 6, 1'b0);
        join
        exp_ids = '{0, 1};
        check_served(exp_ids);

        // Continuous contention from both requesters.
        served.delete();
        fork
            for (int i = 0; i < 6; i++) do_req(0, 1'(i % 2), 2'(1 + i % 3), $urandom, 0, 1'b0);
            for (int i = 0; i < 6; i++) do_req(1, 1'(i % 2), 2'(1 + (i + 1) % 3), $urandom, 0, 1'b0);
        join
        exp_ids.delete();
        for (int i = 0; i < 12; i++) begin
`ifdef REG_ARB_RR_EN
            exp_ids.push_back(i % 2);
`else
            exp_ids.push_back((i < 6) ? 0 : 1);
`endif
        end
        check_served(exp_ids);

        // Register 0 was untouched since the aborted write.
        do_req(0, 1'b0, 2'd0, 32'd0, 3, 1'b0);

        // Random traffic from both requesters.
        fork
            for (int i = 0; i < 20; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                do_req(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 0, 1'b0);
            end
            for (int i = 0; i < 20; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                do_req(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 0, 1'b0);
            end
        join
        for (int a = 0; a < 4; a++) do_req(a % 2, 1'b0, 2'(a), 32'd0, 3, 1'b0);

        repeat (4) @(posedge clk);
        chk("pending_q0_empty", exp_q0.size(), 32'd0);
        chk("pending_q1_empty", exp_q1.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
